// File: rtl/guess_link_ctrl_pkg.sv
// Shared types and default grid geometry for the two-board guess link.
package guess_link_ctrl_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_WIN  = 2'b10,
        RES_LOSE = 2'b01,
        RES_ERR  = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_COMPARE,
        ST_NOTIFY,
        ST_DONE,
        ST_ERROR
    } guess_state_t;

    // Default portrait grid placement on the VGA frame.
    localparam int GRID_X0      = 64;
    localparam int GRID_Y0      = 32;
    localparam int GRID_PITCH_X = 160;
    localparam int GRID_PITCH_Y = 160;
    localparam int GRID_TILE_W  = 128;
    localparam int GRID_TILE_H  = 128;

endpackage

// File: rtl/guess_link_ctrl_sync.sv
// Two-flop synchroniser for the asynchronous peer-board bus.
module link_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk) begin
        sync_p0 <= d;
        sync_p1 <= sync_p0;
    end

    assign q = sync_p1;

endmodule

// File: rtl/guess_link_ctrl.sv
// Grid hit-test, guess latch and 4-phase WIN/LOSE report to the peer board.
// Optional score counters are built when GUESS_LINK_SCORE_EN is defined.
module guess_link_ctrl
    import guess_link_ctrl_pkg::*;
#(
    parameter int N_COLS      = 3,
    parameter int N_ROWS      = 3,
    parameter int ID_W        = 4,
    parameter int X0          = GRID_X0,
    parameter int Y0          = GRID_Y0,
    parameter int PITCH_X     = GRID_PITCH_X,
    parameter int PITCH_Y     = GRID_PITCH_Y,
    parameter int TILE_W      = GRID_TILE_W,
    parameter int TILE_H      = GRID_TILE_H,
    parameter int TIMEOUT_CYC = 65_000_000
`ifdef GUESS_LINK_SCORE_EN
    , parameter int SCORE_W   = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rst_sys,
    input  logic            guess_en,
    input  logic [ID_W-1:0] your_person,
    input  logic [11:0]     xpos,
    input  logic [11:0]     ypos,
    input  logic            mouse_right,
    input  logic            peer_present_i,
    input  logic [ID_W-1:0] peer_person_i,
    input  logic            peer_req_i,
    input  logic [1:0]      peer_res_i,
    input  logic            peer_ack_i,
    output logic            present_o,
    output logic            rst_o,
    output logic [ID_W-1:0] person_o,
    output logic            req_o,
    output logic            ack_o,
    output logic [1:0]      res_o,
    output logic [1:0]      result,
    output logic [ID_W-1:0] selected_id,
    output logic            busy
`ifdef GUESS_LINK_SCORE_EN
    , output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses
`endif
);

    localparam int BUS_W = ID_W + 5;

    logic [BUS_W-1:0] bus_s;
    logic             present_s, req_s, ack_s;
    logic [ID_W-1:0]  person_s;
    logic [1:0]       res_s;

    link_sync #(.WIDTH(BUS_W)) u_sync (
        .clk (clk),
        .d   ({peer_present_i, peer_person_i, peer_req_i, peer_res_i, peer_ack_i}),
        .q   (bus_s)
    );

    assign {present_s, person_s, req_s, res_s, ack_s} = bus_s;

    logic mr_p0, mr_p1, ge_q, req_q;

    always_ff @(posedge clk) begin
        mr_p0 <= mouse_right;
        mr_p1 <= mr_p0;
        ge_q  <= guess_en;
        req_q <= req_s;
    end

    logic click, ge_rise, req_rise, rx_valid;
    assign click    = mr_p0 & ~mr_p1;
    assign ge_rise  = guess_en & ~ge_q;
    assign req_rise = req_s & ~req_q;
    assign rx_valid = req_rise && (res_s == RES_WIN || res_s == RES_LOSE);

    // Scan from the highest index down so overlapping tiles resolve to the lowest id.
    int x_i, y_i, hit_col, hit_row;
    logic col_ok, row_ok, hit;
    logic [ID_W-1:0] hit_id;

    assign x_i = {20'd0, xpos};
    assign y_i = {20'd0, ypos};

    always_comb begin
        hit_col = 0;
        hit_row = 0;
        col_ok  = 1'b0;
        row_ok  = 1'b0;
        for (int c = N_COLS - 1; c >= 0; c--) begin
            if (x_i >= X0 + c * PITCH_X && x_i <= X0 + c * PITCH_X + TILE_W) begin
                col_ok  = 1'b1;
                hit_col = c;
            end
        end
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (y_i >= Y0 + r * PITCH_Y && y_i <= Y0 + r * PITCH_Y + TILE_H) begin
                row_ok  = 1'b1;
                hit_row = r;
            end
        end
    end

    assign hit    = col_ok & row_ok;
    assign hit_id = ID_W'(hit_row * N_COLS + hit_col + 1);

    guess_state_t    state, state_nxt;
    result_t         result_r, result_nxt;
    logic [ID_W-1:0] sel_nxt;
    logic            req_nxt, ack_nxt;
    logic [1:0]      res_nxt;
    logic [31:0]     timer, timer_nxt;

    always_comb begin
        state_nxt  = state;
        result_nxt = result_r;
        sel_nxt    = selected_id;
        req_nxt    = req_o;
        res_nxt    = res_o;
        ack_nxt    = ack_o;
        timer_nxt  = '0;

        // Every peer request is acknowledged, whatever the state.
        if (req_rise) begin
            ack_nxt = 1'b1;
        end else if (!req_s) begin
            ack_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    result_nxt = result_t'(res_s);
                    state_nxt  = ST_DONE;
                end else if (guess_en) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rx_valid) begin
                    result_nxt = result_t'(res_s);
                    state_nxt  = ST_DONE;
                end else if (!guess_en) begin
                    state_nxt = ST_IDLE;
                end else if (click && hit) begin
                    sel_nxt   = hit_id;
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!present_s) begin
                    result_nxt = RES_ERR;
                    state_nxt  = ST_ERROR;
                end else if (selected_id == person_s) begin
                    result_nxt = RES_WIN;
                    res_nxt    = RES_LOSE;
                    req_nxt    = 1'b1;
                    state_nxt  = ST_NOTIFY;
                end else begin
                    result_nxt = RES_LOSE;
                    res_nxt    = RES_WIN;
                    req_nxt    = 1'b1;
                    state_nxt  = ST_NOTIFY;
                end
            end
            ST_NOTIFY: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_DONE;
                end else if (timer == 32'(TIMEOUT_CYC - 1)) begin
                    result_nxt = RES_ERR;
                    req_nxt    = 1'b0;
                    state_nxt  = ST_ERROR;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (rx_valid) begin
                    result_nxt = result_t'(res_s);
                    state_nxt  = ST_DONE;
                end else if (ge_rise) begin
                    result_nxt = RES_NONE;
                    sel_nxt    = '0;
                    state_nxt  = ST_SELECT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || rst_sys) begin
            state       <= ST_IDLE;
            result_r    <= RES_NONE;
            selected_id <= '0;
            req_o       <= 1'b0;
            ack_o       <= 1'b0;
            res_o       <= 2'b00;
            person_o    <= '0;
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            result_r    <= result_nxt;
            selected_id <= sel_nxt;
            req_o       <= req_nxt;
            ack_o       <= ack_nxt;
            res_o       <= res_nxt;
            person_o    <= your_person;
            timer       <= timer_nxt;
        end
    end

    assign present_o = 1'b1;
    assign rst_o     = rst_sys;
    assign result    = result_r;
    assign busy      = (state == ST_COMPARE) || (state == ST_NOTIFY);

`ifdef GUESS_LINK_SCORE_EN
    logic done_entry;
    assign done_entry = (state_nxt == ST_DONE) && (state != ST_DONE);

    // The score survives a system reset so a match can span several rounds.
    always_ff @(posedge clk) begin
        if (rst) begin
            wins   <= '0;
            losses <= '0;
        end else if (!rst_sys && done_entry) begin
            if (result_nxt == RES_WIN && wins != '1) begin
                wins <= wins + 1'b1;
            end
            if (result_nxt == RES_LOSE && losses != '1) begin
                losses <= losses + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_guess_link_ctrl.sv
// Directed self-checking bench for guess_link_ctrl on the default 3x3 grid.
module tb_guess_link_ctrl;

    localparam int ID_W = 4;

    logic            clk, rst, rst_sys, guess_en, mouse_right;
    logic [ID_W-1:0] your_person, peer_person_i, person_o, selected_id;
    logic [11:0]     xpos, ypos;
    logic            peer_present_i, peer_req_i, peer_ack_i;
    logic [1:0]      peer_res_i, res_o, result;
    logic            present_o, rst_o, req_o, ack_o, busy;
`ifdef GUESS_LINK_SCORE_EN
    logic [3:0]      wins, losses;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    guess_link_ctrl #(.TIMEOUT_CYC(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .rst_sys        (rst_sys),
        .guess_en       (guess_en),
        .your_person    (your_person),
        .xpos           (xpos),
        .ypos           (ypos),
        .mouse_right    (mouse_right),
        .peer_present_i (peer_present_i),
        .peer_person_i  (peer_person_i),
        .peer_req_i     (peer_req_i),
        .peer_res_i     (peer_res_i),
        .peer_ack_i     (peer_ack_i),
        .present_o      (present_o),
        .rst_o          (rst_o),
        .person_o       (person_o),
        .req_o          (req_o),
        .ack_o          (ack_o),
        .res_o          (res_o),
        .result         (result),
        .selected_id    (selected_id),
        .busy           (busy)
`ifdef GUESS_LINK_SCORE_EN
        , .wins         (wins),
        .losses         (losses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reselect();
        guess_en = 1'b0;
        tick(1);
        guess_en = 1'b1;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; rst_sys = 1'b0; guess_en = 1'b0; mouse_right = 1'b0;
        your_person = 4'd3; xpos = '0; ypos = '0;
        peer_present_i = 1'b0; peer_person_i = '0; peer_req_i = 1'b0;
        peer_res_i = 2'b00; peer_ack_i = 1'b0;
        tick(2);
        chk("rst_present", present_o, 1);
        chk("rst_result", result, 0);
        chk("rst_req", req_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_person", person_o, 0);
        rst = 1'b0;
        tick(1);
        chk("person_o", person_o, 3);

        // Click on tile (1,2) while idle is ignored.
        xpos = 12'd288; ypos = 12'd416; mouse_right = 1'b1;
        tick(3);
        chk("idle_click_sel", selected_id, 0);
        chk("idle_click_busy", busy, 0);
        mouse_right = 1'b0;
        peer_present_i = 1'b1; peer_person_i = 4'd5;
        tick(3);

        // Centre tile against peer person 5: win.
        guess_en = 1'b1;
        tick(1);
        xpos = 12'd288; ypos = 12'd256; mouse_right = 1'b1;
        tick(2);
        chk("win_sel", selected_id, 5);
        chk("win_cmp_busy", busy, 1);
        chk("win_cmp_req", req_o, 0);
        tick(1);
        chk("win_req", req_o, 1);
        chk("win_result", result, 2'b10);
        chk("win_res_o", res_o, 2'b01);
        tick(5);
        chk("win_req_hold", req_o, 1);
        peer_ack_i = 1'b1;
        tick(2);
        chk("win_req_pre_ack", req_o, 1);
        tick(1);
        chk("win_req_done", req_o, 0);
        chk("win_done_busy", busy, 0);
        chk("win_done_res", result, 2'b10);
        peer_ack_i = 1'b0; mouse_right = 1'b0;
        tick(3);

        // New round against peer person 7: a miss, then an inclusive-corner hit.
        reselect();
        chk("resel_result", result, 0);
        chk("resel_sel", selected_id, 0);
        peer_person_i = 4'd7;
        tick(3);
        xpos = 12'd200; ypos = 12'd256; mouse_right = 1'b1;
        tick(3);
        chk("miss_sel", selected_id, 0);
        chk("miss_busy", busy, 0);
        mouse_right = 1'b0;
        tick(2);
        xpos = 12'd352; ypos = 12'd320; mouse_right = 1'b1;
        tick(3);
        chk("lose_sel", selected_id, 5);
        chk("lose_result", result, 2'b01);
        chk("lose_res_o", res_o, 2'b10);
        chk("lose_req", req_o, 1);
        peer_ack_i = 1'b1;
        tick(3);
        chk("lose_req_done", req_o, 0);
        peer_ack_i = 1'b0; mouse_right = 1'b0;
        tick(3);
`ifdef GUESS_LINK_SCORE_EN
        chk("score_wins1", wins, 1);
        chk("score_losses1", losses, 1);
`endif

        // Peer never acknowledges: error after 100 cycles in NOTIFY.
        reselect();
        xpos = 12'd288; ypos = 12'd256; mouse_right = 1'b1;
        tick(3);
        chk("to_req", req_o, 1);
        tick(99);
        chk("to_req_hold", req_o, 1);
        tick(1);
        chk("to_req_drop", req_o, 0);
        chk("to_result", result, 2'b11);
        chk("to_busy", busy, 0);
        mouse_right = 1'b0;
        tick(2);

        // Peer reports a win for us while selecting.
        reselect();
        peer_res_i = 2'b10; peer_req_i = 1'b1;
        tick(2);
        chk("rx_result_early", result, 0);
        chk("rx_ack_early", ack_o, 0);
        tick(1);
        chk("rx_result", result, 2'b10);
        chk("rx_ack", ack_o, 1);
        tick(3);
        chk("rx_ack_hold", ack_o, 1);
        peer_req_i = 1'b0;
        tick(2);
        chk("rx_ack_tail", ack_o, 1);
        tick(1);
        chk("rx_ack_drop", ack_o, 0);

        // Click-hit and peer request in the same cycle: the peer wins.
        reselect();
        peer_res_i = 2'b01; peer_req_i = 1'b1;
        tick(1);
        xpos = 12'd288; ypos = 12'd256; mouse_right = 1'b1;
        tick(2);
        chk("race_result", result, 2'b01);
        chk("race_sel", selected_id, 0);
        chk("race_ack", ack_o, 1);
        chk("race_busy", busy, 0);
        peer_req_i = 1'b0; mouse_right = 1'b0;
        tick(4);
`ifdef GUESS_LINK_SCORE_EN
        chk("score_wins2", wins, 2);
        chk("score_losses2", losses, 2);
`endif

        // System reset in the middle of a notify.
        reselect();
        mouse_right = 1'b1;
        tick(3);
        chk("rs_req", req_o, 1);
        rst_sys = 1'b1;
        #1;
        chk("rs_rst_o", rst_o, 1);
        tick(1);
        chk("rs_req_drop", req_o, 0);
        chk("rs_result", result, 0);
        chk("rs_busy", busy, 0);
        chk("rs_sel", selected_id, 0);
        rst_sys = 1'b0; mouse_right = 1'b0;
        tick(1);
        chk("rs_rst_o_low", rst_o, 0);
`ifdef GUESS_LINK_SCORE_EN
        chk("score_kept_wins", wins, 2);
        chk("score_kept_losses", losses, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
